fifo_ctrl: RTL

Control block for a single-clock FIFO built around an external dual-port RAM. It sequences the write and read pointers as wrap-around counters (modulo DEPTH, any DEPTH, not only powers of two) and tracks the occupancy count. It also generates the RAM write strobe and addresses, the full/empty flags and sticky error flags. It sits between requesters (producer/consumer) and the storage array.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ptr.sv | 45 ++++
 rtl/fifo_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO control slice: the default depth,
// pointer/count widths derived from it, and matching vector typedefs.
package fifo_pkg;

    localparam int FIFO_DEPTH = 20;

    // Pointer width addresses 0..DEPTH-1; the count must also represent DEPTH itself.
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [FIFO_AW-1:0] fifoPtr_t;
    typedef logic [FIFO_CW-1:0] fifoCount_t;

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH up-counter used for both FIFO pointers. Wraps DEPTH-1 -> 0,
// so DEPTH need not be a power of two. wrap_o pulses on the increment that wraps.
import fifo_pkg::*;

module fifo_ptr #(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstN_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] value_o,
    output logic          wrap_o
);

    logic [AW-1:0] value_q;
    logic [AW-1:0] value_d;
    logic          atMax;

    assign atMax = (value_q == AW'(DEPTH - 1));

    // Clear wins over increment; the last slot folds back to zero instead of reaching DEPTH.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = atMax ? '0 : value_q + AW'(1);
        end
    end

    // Pointer register with asynchronous return to slot zero.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign wrap_o  = inc_i & ~clr_i & atMax;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM: pointers,
// occupancy count, registered full/empty flags and sticky overflow/underflow.
// Optional almost-full/almost-empty outputs are enabled by FIFO_ALMOST_FLAGS_EN.
import fifo_pkg::*;

module fifo_ctrl #(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
`endif
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          iCLR,
    input  logic          iWR,
    input  logic          iRD,
    output logic          oWR_EN,
    output logic [AW-1:0] oWR_ADDR,
    output logic [AW-1:0] oRD_ADDR,
    output logic [CW-1:0] oUSEDW,
    output logic          oFULL,
    output logic          oEMPTY,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic          oALMOST_FULL,
    output logic          oALMOST_EMPTY,
`endif
    output logic          oOVF,
    output logic          oUDF
);

    logic          wrOk;
    logic          rdOk;
    logic          wrWrap;
    logic          rdWrap;
    logic          unusedWrap;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          full_d;
    logic          empty_q;
    logic          empty_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          udf_q;
    logic          udf_d;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic          almostFull_q;
    logic          almostFull_d;
    logic          almostEmpty_q;
    logic          almostEmpty_d;
`endif

    // Accepts look only at the registered flags, so a full FIFO can still
    // take a read and an empty one a write in the same cycle.
    assign wrOk   = iWR & ~full_q & ~iCLR;
    assign rdOk   = iRD & ~empty_q & ~iCLR;
    assign oWR_EN = wrOk;

    fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) uWrPtr (
        .clk_i   (iCLK),
        .rstN_i  (iRST_n),
        .clr_i   (iCLR),
        .inc_i   (wrOk),
        .value_o (oWR_ADDR),
        .wrap_o  (wrWrap)
    );

    fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) uRdPtr (
        .clk_i   (iCLK),
        .rstN_i  (iRST_n),
        .clr_i   (iCLR),
        .inc_i   (rdOk),
        .value_o (oRD_ADDR),
        .wrap_o  (rdWrap)
    );

    assign unusedWrap = wrWrap ^ rdWrap;

    // Next count, flags and sticky errors; flags derive from the next count
    // so they line up with the count register.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | (iWR & full_q);
        udf_d   = udf_q | (iRD & empty_q);
        if (iCLR) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (wrOk && !rdOk) begin
            count_d = count_q + CW'(1);
        end else if (rdOk && !wrOk) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
`ifdef FIFO_ALMOST_FLAGS_EN
        almostFull_d  = (count_d >= CW'(AF_LEVEL));
        almostEmpty_d = (count_d <= CW'(AE_LEVEL));
`endif
    end

    // State registers; reset values match an empty FIFO with no errors.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
`endif
        end else begin
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
`ifdef FIFO_ALMOST_FLAGS_EN
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
`endif
        end
    end

    assign oUSEDW = count_q;
    assign oFULL  = full_q;
    assign oEMPTY = empty_q;
    assign oOVF   = ovf_q;
    assign oUDF   = udf_q;
`ifdef FIFO_ALMOST_FLAGS_EN
    assign oALMOST_FULL  = almostFull_q;
    assign oALMOST_EMPTY = almostEmpty_q;
`endif

endmodule
